ultrasonic_ranger: RTL and testbench



---
 rtl/ultrasonic_ranger_if.sv | 29 ++
 rtl/ultrasonic_ranger.sv | 182 ++++++++++++++++++
 tb/tb_ultrasonic_ranger.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ultrasonic_ranger_if.sv
// rtl/ultrasonic_ranger_if.sv - sensor and result signals of the ultrasonic ranger
interface ultrasonic_ranger_if;
  logic       en;
  logic       echo;
  logic       trig;
  logic [7:0] d;
  logic       DONE;
  logic       timeout;

  // Side that enables measurement and drives the echo line (sensor/consumer side).
  modport master (
    output en,
    output echo,
    input  trig,
    input  d,
    input  DONE,
    input  timeout
  );

  // The ranger itself.
  modport slave (
    input  en,
    input  echo,
    output trig,
    output d,
    output DONE,
    output timeout
  );
endinterface

// File: rtl/ultrasonic_ranger.sv
// rtl/ultrasonic_ranger.sv - ultrasonic trigger/echo timer producing distance in whole centimetres
module ultrasonic_ranger #(
  parameter int TRIG_CYCLES    = 500,
  parameter int CM_CYCLES      = 2900,
  parameter int ECHO_TO_CYCLES = 1500000,
  parameter int PERIOD_CYCLES  = 3000000
) (
  input  logic                clk,
  input  logic                rst_n,
  ultrasonic_ranger_if.slave  bus
);

  localparam int CNT_MAX = (TRIG_CYCLES > ECHO_TO_CYCLES) ? TRIG_CYCLES : ECHO_TO_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PW      = $clog2(PERIOD_CYCLES + 1);
  localparam int SW      = $clog2(CM_CYCLES + 1);

  localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYCLES - 1);
  localparam logic [CW-1:0] ECHO_LAST = CW'(ECHO_TO_CYCLES - 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD_CYCLES - 1);
  localparam logic [SW-1:0] PRE_LAST  = SW'(CM_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TRIG    = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_MEASURE = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;        // trigger width, then echo-rise timeout
  logic [PW-1:0] pcnt;       // measurement period, from trigger start
  logic [SW-1:0] presc;      // clk cycles within the current centimetre
  logic [7:0]    cm;         // whole centimetres counted so far

  logic          echo_s1;
  logic          echo_s2;
  logic          echo_q;
  logic          echo_rise;
  logic          echo_fall;

  logic          trig_q;
  logic [7:0]    d_q;
  logic          done_q;
  logic          timeout_q;

  logic          pre_wrap;
  logic [SW-1:0] presc_next;
  logic [7:0]    cm_next;

  // Two-flop synchroniser for the asynchronous echo plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_s1 <= 1'b0;
      echo_s2 <= 1'b0;
      echo_q  <= 1'b0;
    end else begin
      echo_s1 <= bus.echo;
      echo_s2 <= echo_s1;
      echo_q  <= echo_s2;
    end
  end

  assign echo_rise = echo_s2 & ~echo_q;
  assign echo_fall = ~echo_s2 & echo_q;

  // Next prescaler/centimetre values; every MEASURE cycle (including the one seeing the fall) counts one high cycle.
  always_comb begin
    pre_wrap   = (presc == PRE_LAST);
    presc_next = pre_wrap ? '0 : presc + SW'(1);
    cm_next    = cm;
    if (pre_wrap && (cm != 8'hff)) begin
      cm_next = cm + 8'd1;
    end
  end

  // Measurement sequencer: trigger, wait for echo, time it, then hold the result until the period ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pcnt      <= '0;
      presc     <= '0;
      cm        <= '0;
      trig_q    <= 1'b0;
      d_q       <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // The period counter free-runs from trigger start and parks at its last value.
      if (pcnt != PER_LAST) begin
        pcnt <= pcnt + PW'(1);
      end

      case (state)
        S_IDLE: begin
          trig_q    <= 1'b0;
          done_q    <= 1'b0;
          timeout_q <= 1'b0;
          if (bus.en) begin
            state  <= S_TRIG;
            trig_q <= 1'b1;
            cnt    <= '0;
            pcnt   <= '0;
          end
        end

        S_TRIG: begin
          if (cnt == TRIG_LAST) begin
            state  <= S_WAIT;
            trig_q <= 1'b0;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_WAIT: begin
          // An echo already high here never produces a rise, so it is ignored until it re-rises.
          if (echo_rise) begin
            state <= S_MEASURE;
            presc <= '0;
            cm    <= '0;
          end else if (cnt == ECHO_LAST) begin
            state     <= S_HOLD;
            d_q       <= 8'hff;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_MEASURE: begin
          if (echo_fall) begin
            state     <= S_HOLD;
            d_q       <= cm_next;
            done_q    <= 1'b1;
            timeout_q <= 1'b0;
          end else if (pcnt == PER_LAST) begin
            // Echo stuck high: report a timeout and give the result a full period of hold time.
            state     <= S_HOLD;
            d_q       <= 8'hff;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            pcnt      <= '0;
          end else begin
            presc <= presc_next;
            cm    <= cm_next;
          end
        end

        S_HOLD: begin
          if (pcnt == PER_LAST) begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            if (bus.en) begin
              state  <= S_TRIG;
              trig_q <= 1'b1;
              cnt    <= '0;
              pcnt   <= '0;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        default: begin
          state     <= S_IDLE;
          trig_q    <= 1'b0;
          done_q    <= 1'b0;
          timeout_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.trig    = trig_q;
  assign bus.d       = d_q;
  assign bus.DONE    = done_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb/tb_ultrasonic_ranger.sv - randomized self-checking bench for ultrasonic_ranger
module tb_ultrasonic_ranger;
  localparam int TRIG = 4;
  localparam int CM   = 10;
  localparam int ETO  = 300;
  localparam int PER  = 5000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ultrasonic_ranger_if bus();

  ultrasonic_ranger #(
    .TRIG_CYCLES   (TRIG),
    .CM_CYCLES     (CM),
    .ECHO_TO_CYCLES(ETO),
    .PERIOD_CYCLES (PER)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Result-level invariants watched continuously: d frozen while DONE, DONE gap >= trigger width.
  int         d_viol   = 0;
  int         gap_viol = 0;
  int         low_run  = 1000;
  logic       done_p   = 1'b0;
  logic [7:0] d_p      = 8'd0;

  always @(negedge clk) begin
    if (done_p && bus.DONE && (bus.d != d_p)) d_viol++;
    if (bus.DONE && !done_p && (low_run < TRIG)) gap_viol++;
    low_run = bus.DONE ? 0 : low_run + 1;
    done_p  = bus.DONE;
    d_p     = bus.d;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_vec %0d", n_vec);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: whole centimetres of an echo of the given width, saturating at 255.
  function automatic int ref_cm(input int width);
    int q;
    q = width / CM;
    return (q > 255) ? 255 : q;
  endfunction

  task automatic wait_trig(input logic lvl, input int limit, input string tag);
    int k;
    k = 0;
    while (bus.trig !== lvl && k < limit) begin
      tick();
      k++;
    end
    check_eq(tag, int'(bus.trig), int'(lvl));
  endtask

  task automatic wait_done(input int limit, input string tag, output int k);
    k = 0;
    while (bus.DONE !== 1'b1 && k < limit) begin
      tick();
      k++;
    end
    check_eq(tag, int'(bus.DONE), 1);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_trig"},    int'(bus.trig),    0);
    check_eq({tag, "_d"},       int'(bus.d),       0);
    check_eq({tag, "_done"},    int'(bus.DONE),    0);
    check_eq({tag, "_timeout"}, int'(bus.timeout), 0);
  endtask

  task automatic run_measure(input int dly, input int width);
    int w;
    int k;
    wait_trig(1'b1, PER + 100, $sformatf("trig_rise w=%0d", width));
    w = 0;
    while (bus.trig === 1'b1 && w < 100) begin
      tick();
      w++;
    end
    check_eq($sformatf("trig_width w=%0d", width), w, TRIG);
    check_eq($sformatf("done_low w=%0d", width), int'(bus.DONE), 0);
    repeat (dly) tick();
    bus.echo = 1'b1;
    repeat (width) tick();
    bus.echo = 1'b0;
    wait_done(50, $sformatf("done_seen w=%0d", width), k);
    check_eq($sformatf("latency w=%0d", width), k, 3);
    check_eq($sformatf("d w=%0d", width), int'(bus.d), ref_cm(width));
    check_eq($sformatf("timeout w=%0d", width), int'(bus.timeout), 0);
  endtask

  initial begin
    int k;
    int t0;
    int hi;
    bus.en   = 1'b0;
    bus.echo = 1'b0;

    // Reset values, then en=0 keeps the block idle.
    repeat (3) tick();
    check_zero("rst");
    rst_n = 1'b1;
    hi = 0;
    repeat (100) begin
      tick();
      if (bus.trig) hi++;
    end
    check_eq("idle_no_trig", hi, 0);
    check_eq("idle_done", int'(bus.DONE), 0);

    // Nominal measurement, then an asynchronous reset while the result is held.
    bus.en = 1'b1;
    run_measure(20, 1234);
    repeat (50) tick();
    check_eq("hold_d", int'(bus.d), 123);
    #2 rst_n = 1'b0;
    #1 check_zero("arst");
    bus.en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    hi = 0;
    repeat (100) begin
      tick();
      if (bus.trig) hi++;
    end
    check_eq("arst_no_trig", hi, 0);
    bus.en = 1'b1;

    // Short, saturating, boundary and random echoes.
    run_measure(20, 9);
    run_measure($urandom_range(5, 200), 3000);
    run_measure($urandom_range(5, 200), 10);
    for (int i = 0; i < 2; i++) begin
      run_measure($urandom_range(5, 200), $urandom_range(1, 3200));
    end

    // No echo: timeout result ETO cycles after trig falls; period from trig start.
    wait_trig(1'b1, PER + 100, "noecho_trig");
    t0 = cyc;
    wait_trig(1'b0, 50, "noecho_trig_fall");
    wait_done(ETO + 100, "noecho_done", k);
    check_eq("noecho_delay", k, ETO);
    check_eq("noecho_d", int'(bus.d), 255);
    check_eq("noecho_timeout", int'(bus.timeout), 1);
    wait_trig(1'b1, PER + 100, "noecho_next_trig");
    check_eq("period", cyc - t0, PER);

    // Stuck echo: result at period expiry, then a new trigger before any further result.
    t0 = cyc;
    wait_trig(1'b0, 50, "stuck_trig_fall");
    repeat (20) tick();
    bus.echo = 1'b1;
    wait_done(PER + 100, "stuck_done", k);
    check_eq("stuck_at_period", cyc - t0, PER);
    check_eq("stuck_d", int'(bus.d), 255);
    check_eq("stuck_timeout", int'(bus.timeout), 1);
    k = 0;
    while (bus.DONE === 1'b1 && k < PER + 100) begin
      tick();
      k++;
    end
    check_eq("stuck_done_fall", int'(bus.DONE), 0);
    check_eq("stuck_retrig", int'(bus.trig), 1);
    wait_done(1000, "stuck_next_done", k);
    check_eq("stuck_gap_ge_trig", int'(k >= TRIG), 1);
    check_eq("stuck_gap", k, TRIG + ETO);
    check_eq("stuck_next_timeout", int'(bus.timeout), 1);
    bus.echo = 1'b0;

    // Reset in the middle of an echo: the stale tail must not be measured.
    wait_trig(1'b1, PER + 100, "mrst_trig");
    wait_trig(1'b0, 50, "mrst_trig_fall");
    repeat (20) tick();
    bus.echo = 1'b1;
    repeat (600) tick();
    #2 rst_n = 1'b0;
    #1 check_zero("mrst");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (1234 - 602) tick();
    bus.echo = 1'b0;
    check_eq("mrst_done", int'(bus.DONE), 1);
    check_eq("mrst_d", int'(bus.d), 255);
    check_eq("mrst_timeout", int'(bus.timeout), 1);
    run_measure($urandom_range(5, 200), $urandom_range(1, 3200));

    check_eq("d_stable_violations", d_viol, 0);
    check_eq("done_gap_violations", gap_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
